// File: rtl/demux_lane_sched.sv
// demux_lane_sched: round-robin scheduler that serializes one of four 32-bit
// requester words into a byte stream, one byte per clk_4f cycle.
module demux_lane_sched #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  lane_mask,
    input  logic [31:0] lane_0,
    input  logic [31:0] lane_1,
    input  logic [31:0] lane_2,
    input  logic [31:0] lane_3,
    input  logic        valid_0,
    input  logic        valid_1,
    input  logic        valid_2,
    input  logic        valid_3,
    output logic        ready_0,
    output logic        ready_1,
    output logic        ready_2,
    output logic        ready_3,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic [1:0]  lane_id,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic [1:0]  rr_ptr_r;
    logic [1:0]  grant_r;
    logic [31:0] word_r;
    logic [3:0]  ready_r;
    logic [7:0]  data_r;
    logic        valid_r;
    logic [1:0]  lane_id_r;
    logic        busy_r;

    logic [3:0]  req_s;
    logic [2:0]  pick_s;
    logic        grant_vld_s;
    logic [1:0]  grant_idx_s;
    logic [31:0] grant_word_s;
    logic [7:0]  byte_s;

    // First active request found scanning ptr, ptr+1, ... (mod 4); bit 2 flags a hit.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + k[1:0];
            if (req[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Byte n of the word in transmission order.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] n);
        logic [1:0] pos;
        logic [7:0] b;
        pos = MSB_FIRST ? (2'd3 - n) : n;
        case (pos)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Qualify requests and arbitrate among them.
    always_comb begin
        req_s       = {valid_3, valid_2, valid_1, valid_0} & lane_mask & {4{enable}};
        pick_s      = rr_pick(req_s, rr_ptr_r);
        grant_vld_s = pick_s[2];
        grant_idx_s = pick_s[1:0];
    end

    // Word of the winning lane and the byte currently due from the word register.
    always_comb begin
        case (grant_idx_s)
            2'd0:    grant_word_s = lane_0;
            2'd1:    grant_word_s = lane_1;
            2'd2:    grant_word_s = lane_2;
            2'd3:    grant_word_s = lane_3;
            default: grant_word_s = 32'h0000_0000;
        endcase
        byte_s = pick_byte(word_r, cnt_r);
    end

    // Scheduler FSM with registered outputs; a grant at cnt 3 chains words with no bubble.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 2'd0;
            rr_ptr_r  <= 2'd0;
            grant_r   <= 2'd0;
            word_r    <= 32'h0000_0000;
            ready_r   <= 4'b0000;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            lane_id_r <= 2'd0;
            busy_r    <= 1'b0;
        end else begin
            ready_r <= 4'b0000;
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (grant_vld_s) begin
                        word_r   <= grant_word_s;
                        grant_r  <= grant_idx_s;
                        ready_r  <= 4'b0001 << grant_idx_s;
                        rr_ptr_r <= grant_idx_s + 2'd1;
                        cnt_r    <= 2'd0;
                        state_r  <= ST_SEND;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    data_r    <= byte_s;
                    valid_r   <= 1'b1;
                    lane_id_r <= grant_r;
                    cnt_r     <= cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        if (grant_vld_s) begin
                            word_r   <= grant_word_s;
                            grant_r  <= grant_idx_s;
                            ready_r  <= 4'b0001 << grant_idx_s;
                            rr_ptr_r <= grant_idx_s + 2'd1;
                            cnt_r    <= 2'd0;
                            state_r  <= ST_SEND;
                            busy_r   <= 1'b1;
                        end else begin
                            state_r  <= ST_IDLE;
                            busy_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_SEND;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_0   = ready_r[0];
    assign ready_1   = ready_r[1];
    assign ready_2   = ready_r[2];
    assign ready_3   = ready_r[3];
    assign data_out  = data_r;
    assign valid_out = valid_r;
    assign lane_id   = lane_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Bench for demux_lane_sched: directed table, hand-written corner sequences and a
// randomized run against a byte-queue reference model; MSB- and LSB-first instances.
module tb_demux_lane_sched;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  lane_mask;
    logic [31:0] lw [4];
    logic [3:0]  vld;

    wire  [3:0]  rdy_m, rdy_l;
    wire  [7:0]  dout_m, dout_l;
    wire         vout_m, vout_l, busy_m, busy_l;
    wire  [1:0]  lid_m, lid_l;

    int checks = 0;
    int failures = 0;

    always #5 clk_4f = ~clk_4f;

    demux_lane_sched #(.MSB_FIRST(1'b1)) u_dut (
        .clk_4f(clk_4f), .reset(reset), .enable(enable), .lane_mask(lane_mask),
        .lane_0(lw[0]), .lane_1(lw[1]), .lane_2(lw[2]), .lane_3(lw[3]),
        .valid_0(vld[0]), .valid_1(vld[1]), .valid_2(vld[2]), .valid_3(vld[3]),
        .ready_0(rdy_m[0]), .ready_1(rdy_m[1]), .ready_2(rdy_m[2]), .ready_3(rdy_m[3]),
        .data_out(dout_m), .valid_out(vout_m), .lane_id(lid_m), .busy(busy_m)
    );

    demux_lane_sched #(.MSB_FIRST(1'b0)) u_dut_lsb (
        .clk_4f(clk_4f), .reset(reset), .enable(enable), .lane_mask(lane_mask),
        .lane_0(lw[0]), .lane_1(lw[1]), .lane_2(lw[2]), .lane_3(lw[3]),
        .valid_0(vld[0]), .valid_1(vld[1]), .valid_2(vld[2]), .valid_3(vld[3]),
        .ready_0(rdy_l[0]), .ready_1(rdy_l[1]), .ready_2(rdy_l[2]), .ready_3(rdy_l[3]),
        .data_out(dout_l), .valid_out(vout_l), .lane_id(lid_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of pending bytes ----------------
    typedef struct {
        logic [31:0] w;
        logic [1:0]  lane;
        int          idx;
    } mq_t;
    mq_t        mq[$];
    int         m_rr;
    logic [3:0] m_ready;
    logic       m_valid;
    logic [7:0] m_data, m_dlsb;
    logic [1:0] m_lane;

    function automatic void model_reset();
        mq.delete();
        m_rr = 0; m_ready = 4'b0000; m_valid = 1'b0;
        m_data = 8'h00; m_dlsb = 8'h00; m_lane = 2'd0;
    endfunction

    // One clock edge: emit the next queued byte; when no bytes remain, grant a new word.
    function automatic void model_edge();
        mq_t e;
        bit  found;
        m_ready = 4'b0000;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_data  = e.w[31 - 8*e.idx -: 8];
            m_dlsb  = e.w[8*e.idx +: 8];
            m_lane  = e.lane;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (mq.size() == 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_rr + k) % 4;
                if (!found && enable && lane_mask[i] && vld[i]) begin
                    found = 1'b1;
                    for (int b = 0; b < 4; b++) mq.push_back('{w: lw[i], lane: 2'(i), idx: b});
                    m_ready[i] = 1'b1;
                    m_rr = (i + 1) % 4;
                end
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0; lane_mask = 4'h0; vld = 4'h0;
        repeat (2) @(posedge clk_4f);
        #1;
        chk("rst_ready", {28'd0, rdy_m}, 32'd0);
        chk("rst_valid", {31'd0, vout_m}, 32'd0);
        chk("rst_data", {24'd0, dout_m}, 32'd0);
        chk("rst_lane", {30'd0, lid_m}, 32'd0);
        chk("rst_busy", {31'd0, busy_m}, 32'd0);
        @(negedge clk_4f);
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [3:0] vld;
        logic [3:0] rdy;
        logic       vo;
        logic [7:0] d;
        logic [7:0] dl;
        logic [1:0] lid;
    } vec_t;
    vec_t tbl [12];

    initial begin
        reset = 1'b1; enable = 1'b0; lane_mask = 4'h0; vld = 4'h0;
        for (int i = 0; i < 4; i++) lw[i] = 32'h0;
        #2;

        // single words on lane 0 then lane 1, checked in both byte orders
        tbl[0]  = '{4'b0001, 4'b0001, 1'b0, 8'h00, 8'h00, 2'd0};
        tbl[1]  = '{4'b0000, 4'b0000, 1'b1, 8'hA1, 8'hD4, 2'd0};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 8'hB2, 8'hC3, 2'd0};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 8'hC3, 8'hB2, 2'd0};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 8'hD4, 8'hA1, 2'd0};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 8'hD4, 8'hA1, 2'd0};
        tbl[6]  = '{4'b0010, 4'b0010, 1'b0, 8'hD4, 8'hA1, 2'd0};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 8'h01, 8'h04, 2'd1};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 8'h02, 8'h03, 2'd1};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 8'h03, 8'h02, 2'd1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 8'h04, 8'h01, 2'd1};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 8'h04, 8'h01, 2'd1};

        do_reset();
        enable = 1'b1; lane_mask = 4'hF;
        lw[0] = 32'hA1B2C3D4; lw[1] = 32'h01020304; lw[2] = 32'h33333333; lw[3] = 32'h44444444;
        for (int r = 0; r < 12; r++) begin
            vld = tbl[r].vld;
            @(posedge clk_4f); #1;
            chk("tbl_ready", {28'd0, rdy_m}, {28'd0, tbl[r].rdy});
            chk("tbl_valid", {31'd0, vout_m}, {31'd0, tbl[r].vo});
            chk("tbl_data", {24'd0, dout_m}, {24'd0, tbl[r].d});
            chk("tbl_lane", {30'd0, lid_m}, {30'd0, tbl[r].lid});
            chk("tbl_data_lsb", {24'd0, dout_l}, {24'd0, tbl[r].dl});
            chk("tbl_busy", {31'd0, busy_m}, {31'd0, (tbl[r].rdy != 4'b0000) || (r inside {1,2,3,7,8,9})});
        end

        // all lanes continuously valid: 0,1,2,3,0,... with no gaps
        do_reset();
        enable = 1'b1; lane_mask = 4'hF; vld = 4'hF;
        for (int i = 0; i < 4; i++) lw[i] = 32'h11111111 * (i + 1);
        @(posedge clk_4f); #1;
        chk("rr_first_ready", {28'd0, rdy_m}, 32'd1);
        for (int n = 0; n < 40; n++) begin
            int g;
            g = (n / 4) % 4;
            @(posedge clk_4f); #1;
            chk("rr_valid", {31'd0, vout_m}, 32'd1);
            chk("rr_data", {24'd0, dout_m}, 32'h11 * (g + 1));
            chk("rr_lane", {30'd0, lid_m}, g);
            chk("rr_ready", {28'd0, rdy_m}, (n % 4 == 3) ? (32'd1 << ((g + 1) % 4)) : 32'd0);
        end

        // mask 0101: only lanes 0 and 2 served
        do_reset();
        enable = 1'b1; lane_mask = 4'b0101; vld = 4'hF;
        @(posedge clk_4f); #1;
        chk("mask_first_ready", {28'd0, rdy_m}, 32'd1);
        for (int n = 0; n < 24; n++) begin
            int g;
            g = ((n / 4) % 2) * 2;
            @(posedge clk_4f); #1;
            chk("mask_ready13", {30'd0, rdy_m[3], rdy_m[1]}, 32'd0);
            chk("mask_lane", {30'd0, lid_m}, g);
            chk("mask_data", {24'd0, dout_m}, 32'h11 * (g + 1));
        end

        // enable dropped after the 2nd byte: word completes, then idle
        do_reset();
        enable = 1'b1; lane_mask = 4'hF; vld = 4'b0001; lw[0] = 32'h5A6B7C8D;
        @(posedge clk_4f); #1;
        chk("en_ready", {28'd0, rdy_m}, 32'd1);
        @(posedge clk_4f); #1;
        chk("en_b0", {23'd0, vout_m, dout_m}, 32'h15A);
        @(posedge clk_4f); #1;
        chk("en_b1", {23'd0, vout_m, dout_m}, 32'h16B);
        enable = 1'b0;
        @(posedge clk_4f); #1;
        chk("en_b2", {23'd0, vout_m, dout_m}, 32'h17C);
        @(posedge clk_4f); #1;
        chk("en_b3", {23'd0, vout_m, dout_m}, 32'h18D);
        chk("en_no_ready_b3", {28'd0, rdy_m}, 32'd0);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk_4f); #1;
            chk("en_idle_valid", {31'd0, vout_m}, 32'd0);
            chk("en_idle_ready", {28'd0, rdy_m}, 32'd0);
            chk("en_idle_busy", {31'd0, busy_m}, 32'd0);
        end

        // asynchronous reset mid-word, then lane 3 alone
        do_reset();
        enable = 1'b1; lane_mask = 4'hF; vld = 4'b0001; lw[0] = 32'hA1B2C3D4;
        @(posedge clk_4f); #1;
        vld = 4'b0000;
        @(posedge clk_4f); #1;
        @(posedge clk_4f); #1;
        chk("ar_pre_data", {24'd0, dout_m}, 32'hB2);
        @(negedge clk_4f); #2;
        reset = 1'b0;
        #1;
        chk("ar_outs_m", {dout_m, lid_m, vout_m, busy_m, rdy_m}, 32'd0);
        chk("ar_outs_l", {dout_l, lid_l, vout_l, busy_l, rdy_l}, 32'd0);
        @(negedge clk_4f);
        reset = 1'b1;
        vld = 4'b1000; lw[3] = 32'hCAFE0F0E;
        @(posedge clk_4f); #1;
        chk("ar_ready3", {28'd0, rdy_m}, 32'b1000);
        vld = 4'b0000;
        lw[0] = 32'hCAFE0F0E;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk_4f); #1;
            chk("ar_byte", {21'd0, vout_m, lid_m, dout_m}, {21'd0, 1'b1, 2'd3, lw[0][31 - 8*b -: 8]});
        end
        @(posedge clk_4f); #1;
        chk("ar_end_valid", {31'd0, vout_m}, 32'd0);

        // randomized run against the reference model
        do_reset();
        enable = 1'b1; lane_mask = 4'hF; vld = 4'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk_4f);
            model_edge();
            #1;
            chk("rnd_ready", {28'd0, rdy_m}, {28'd0, m_ready});
            chk("rnd_valid", {31'd0, vout_m}, {31'd0, m_valid});
            chk("rnd_data", {24'd0, dout_m}, {24'd0, m_data});
            chk("rnd_data_lsb", {24'd0, dout_l}, {24'd0, m_dlsb});
            chk("rnd_lane", {30'd0, lid_m}, {30'd0, m_lane});
            chk("rnd_busy", {31'd0, busy_m}, {31'd0, mq.size() > 0});
            for (int i = 0; i < 4; i++) begin
                if (m_ready[i]) begin
                    vld[i] = 1'($urandom_range(0, 1));
                    lw[i]  = $urandom;
                end else if (!vld[i] && $urandom_range(0, 2) == 0) begin
                    vld[i] = 1'b1;
                    lw[i]  = $urandom;
                end
            end
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) lane_mask = 4'($urandom_range(0, 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_lane_sched.md
DEMUX_LANE_SCHED -- requirements
Module: demux_lane_sched

Interface
REQ-001 Parameter: MSB_FIRST, default 1, byte order (1: [31:24] first, 0: [7:0] first).
REQ-002 clk_4f  input  1  byte-rate clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 enable  input  1  scheduler enable; 0 = no new grants.
REQ-005 lane_mask  input  4  per-lane request enable; bit i = 0 ignores lane i.
REQ-006 lane_0..lane_3  input  32 each  requester words.
REQ-007 valid_0..valid_3  input  1 each  requester word valid.
REQ-008 ready_0..ready_3  output  1 each  registered one-cycle word-accept pulse.
REQ-009 data_out  output  8  serialized byte.
REQ-010 valid_out  output  1  data_out valid.
REQ-011 lane_id  output  2  source lane of the current data_out byte.
REQ-012 busy  output  1  high while state is SEND.

Function
REQ-013 Request i SHALL be active when valid_i=1, lane_mask[i]=1 and enable=1.
REQ-014 FSM states SHALL be IDLE and SEND; 2-bit byte counter cnt; 2-bit round-robin pointer rr_ptr; 32-bit word register; 2-bit grant register.
REQ-015 Arbitration SHALL select the first active request scanning rr_ptr, rr_ptr+1, ... (mod 4); after a grant to lane g, rr_ptr SHALL become g+1 mod 4.
REQ-016 IDLE, no active request: stay IDLE; valid_out=0; ready_*=0; data_out and lane_id hold.
REQ-017 IDLE, active request: capture lane_g into word register, grant<=g, ready_g=1 for next cycle only, cnt<=0, go SEND.
REQ-018 SEND: each cycle drive byte cnt of the word register (order per MSB_FIRST), valid_out=1, lane_id=grant, cnt<=cnt+1.
REQ-019 SEND with cnt=3: arbitrate as in REQ-015; on a grant capture the new word, pulse ready, cnt<=0, stay SEND (zero-bubble back-to-back); otherwise go IDLE.
REQ-020 Latency: capture edge to first valid byte = 1 cycle; sustained throughput = 1 byte/cycle with continuous requests.
REQ-021 At most one ready_* SHALL be high in any cycle; ready never asserts in SEND with cnt 0..2.
REQ-022 Deassertion of enable, lane_mask bit, or valid_g during SEND SHALL NOT abort the word in flight; the 4 bytes always complete.
REQ-023 Requesters hold lane_i/valid_i stable until their ready_i pulse; a source whose word was captured SHALL NOT be re-captured in the ready cycle (guaranteed by REQ-021).
REQ-024 Simultaneous requests on all lanes from reset SHALL be served in order 0,1,2,3,0,...
REQ-025 busy SHALL equal (state==SEND).

Reset
REQ-026 reset=0 SHALL immediately, independent of clk_4f, set state IDLE, cnt=0, rr_ptr=0, grant=0, word register=0, data_out=0, valid_out=0, lane_id=0, ready_*=0, busy=0.
REQ-027 Reset asserted mid-word SHALL drop the partial word; no byte of it appears after release.
REQ-028 First grant SHALL be possible on the first rising edge after reset deassertion.

Verification
REQ-029 Single word: lane_0=0xA1B2C3D4, valid_0=1, mask=4'hF, MSB_FIRST=1 -> ready_0 one cycle, then data_out A1,B2,C3,D4 with valid_out=1, lane_id=0, then valid_out=0.
REQ-030 All four lanes valid continuously (lane_i=0x11111111*(i+1)) -> bytes 11x4 then 22x4, 33x4, 44x4, 11x4..., valid_out never drops, ready pulses every 4 cycles.
REQ-031 lane_mask=4'b0101, all valid -> grants alternate lanes 0 and 2 only; ready_1, ready_3 stay 0.
REQ-032 enable dropped after 2nd byte of a word -> remaining 2 bytes output, then IDLE, no further ready pulses.
REQ-033 reset=0 asynchronously mid-word (between edges) -> all outputs 0 immediately; after release with valid_3 only -> rr_ptr=0 scan grants lane 3, full word output.
REQ-034 MSB_FIRST=0, lane_1=0x01020304 -> bytes 04,03,02,01, lane_id=1.
